// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared widths and enums for the MEM stage slice
package memory_stage_pkg;

    localparam int DATA_W = 32;
    localparam int RSEL_W = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [RSEL_W-1:0] regbits_t;

    // write-back source select, as muxed by write_back
    typedef enum logic [1:0] {ALUr, DLoad, Jal, Lui} regsel_t;

    // data-cache request progress for the instruction held in EX/MEM
    typedef enum logic [1:0] {IDLE, REQ, DONE} memstate_t;

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - data-cache request/response bundle between MEM and dcache
interface memory_stage_if
    import memory_stage_pkg::*;
#(
    parameter int WORD_W = DATA_W
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dload
    );
endinterface

// File: rtl/memory_stage_dmem_req_ctrl.sv
// rtl/memory_stage_dmem_req_ctrl.sv - data-cache request FSM, stall and advance generation
module dmem_req_ctrl
    import memory_stage_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    input  logic      flush,
    input  logic      ihit,
    input  logic      halt,
    input  logic      ex_mem_op,
    input  logic      R_dREN,
    input  logic      R_dWEN,
    input  logic      dhit,
    output memstate_t state,
    output logic      advance,
    output logic      dmemREN,
    output logic      dmemWEN,
    output logic      mem_busy
);

    // dhit releases the stall in the same cycle so the next instruction can move in
    assign mem_busy = (state == REQ) & ~dhit;
    assign advance  = ihit & ~mem_busy & ~halt;

    // requests only in REQ, so a serviced store is never reissued while held in DONE
    assign dmemREN = (state == REQ) & R_dREN;
    assign dmemWEN = (state == REQ) & R_dWEN;

    // request state: flush drops any outstanding access, capture restarts it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else if (advance) begin
            state <= ex_mem_op ? REQ : IDLE;
        end else if ((state == REQ) && dhit) begin
            state <= DONE;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - EX/MEM register and data-cache access stage (MEM_FWD_EN adds forwarding outputs)
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int WORD_W = DATA_W,
    parameter int REG_W  = RSEL_W
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              ihit,
    input  logic [WORD_W-1:0] ex_nPC,
    input  logic [WORD_W-1:0] ex_ALUOut,
    input  logic [WORD_W-1:0] ex_lui,
    input  logic [WORD_W-1:0] ex_store,
    input  regsel_t           ex_regSel,
    input  logic              ex_regWr,
    input  logic [REG_W-1:0]  ex_regDst,
    input  logic              ex_dREN,
    input  logic              ex_dWEN,
    input  logic              ex_halt,
    memory_stage_if.master    dif,
    output logic              mem_busy,
    output logic [WORD_W-1:0] nPC,
    output logic [WORD_W-1:0] ALUOut,
    output logic [WORD_W-1:0] lui,
    output logic [WORD_W-1:0] dmemload,
    output regsel_t           regSel,
    output logic              regWr,
    output logic [REG_W-1:0]  regDst,
`ifdef MEM_FWD_EN
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [WORD_W-1:0] fwd_data,
`endif
    output logic              halt
);

    logic [WORD_W-1:0] R_nPC, R_ALUOut, R_lui, R_store, R_load;
    regsel_t           R_regSel;
    logic              R_regWr, R_dREN, R_dWEN;
    logic [REG_W-1:0]  R_regDst;
    memstate_t         state;
    logic              advance;

    dmem_req_ctrl u_ctrl (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .ihit      (ihit),
        .halt      (halt),
        .ex_mem_op (ex_dREN | ex_dWEN),
        .R_dREN    (R_dREN),
        .R_dWEN    (R_dWEN),
        .dhit      (dif.dhit),
        .state     (state),
        .advance   (advance),
        .dmemREN   (dif.dmemREN),
        .dmemWEN   (dif.dmemWEN),
        .mem_busy  (mem_busy)
    );

    // EX/MEM register; flush kills the write and any pending access, halt freezes captures
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            R_nPC    <= '0;
            R_ALUOut <= '0;
            R_lui    <= '0;
            R_store  <= '0;
            R_load   <= '0;
            R_regSel <= ALUr;
            R_regWr  <= 1'b0;
            R_regDst <= '0;
            R_dREN   <= 1'b0;
            R_dWEN   <= 1'b0;
            halt     <= 1'b0;
        end else if (flush) begin
            R_regWr  <= 1'b0;
            R_dREN   <= 1'b0;
            R_dWEN   <= 1'b0;
            R_regSel <= ALUr;
        end else begin
            if (advance) begin
                R_nPC    <= ex_nPC;
                R_ALUOut <= ex_ALUOut;
                R_lui    <= ex_lui;
                R_store  <= ex_store;
                R_regSel <= ex_regSel;
                R_regWr  <= ex_regWr;
                R_regDst <= ex_regDst;
                R_dREN   <= ex_dREN;
                R_dWEN   <= ex_dWEN;
                if (ex_halt) begin
                    halt <= 1'b1;
                end
            end
            if ((state == REQ) && dif.dhit && R_dREN) begin
                R_load <= dif.dload;
            end
        end
    end

    assign dif.dmemaddr  = R_ALUOut;
    assign dif.dmemstore = R_store;

    // load data is visible in the hit cycle, then held from R_load
    assign dmemload = ((state == REQ) && dif.dhit) ? dif.dload : R_load;

    assign nPC    = R_nPC;
    assign ALUOut = R_ALUOut;
    assign lui    = R_lui;
    assign regSel = R_regSel;
    assign regWr  = R_regWr;
    assign regDst = R_regDst;

`ifdef MEM_FWD_EN
    assign fwd_valid = R_regWr & ~mem_busy;
    assign fwd_reg   = R_regDst;

    // same source selection write_back applies
    always_comb begin
        fwd_data = R_ALUOut;
        case (R_regSel)
            DLoad:   fwd_data = dmemload;
            Jal:     fwd_data = R_nPC;
            Lui:     fwd_data = R_lui;
            default: fwd_data = R_ALUOut;
        endcase
    end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed and randomized checks of memory_stage against a transaction model
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush, ihit;
    logic [31:0] ex_nPC, ex_ALUOut, ex_lui, ex_store;
    regsel_t     ex_regSel;
    logic        ex_regWr, ex_dREN, ex_dWEN, ex_halt;
    logic [4:0]  ex_regDst;
    logic        mem_busy, regWr, halt;
    logic [31:0] nPC, ALUOut, lui, dmemload;
    regsel_t     regSel;
    logic [4:0]  regDst;
`ifdef MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif

    memory_stage_if dif ();

    memory_stage dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .ihit      (ihit),
        .ex_nPC    (ex_nPC),
        .ex_ALUOut (ex_ALUOut),
        .ex_lui    (ex_lui),
        .ex_store  (ex_store),
        .ex_regSel (ex_regSel),
        .ex_regWr  (ex_regWr),
        .ex_regDst (ex_regDst),
        .ex_dREN   (ex_dREN),
        .ex_dWEN   (ex_dWEN),
        .ex_halt   (ex_halt),
        .dif       (dif),
        .mem_busy  (mem_busy),
        .nPC       (nPC),
        .ALUOut    (ALUOut),
        .lui       (lui),
        .dmemload  (dmemload),
        .regSel    (regSel),
        .regWr     (regWr),
        .regDst    (regDst),
`ifdef MEM_FWD_EN
        .fwd_valid (fwd_valid),
        .fwd_reg   (fwd_reg),
        .fwd_data  (fwd_data),
`endif
        .halt      (halt)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic rd,
                         input logic wr, input regsel_t sel, input logic rw);
        ex_ALUOut = addr;
        ex_store  = data;
        ex_nPC    = addr + 32'd4;
        ex_lui    = {data[15:0], 16'h0000};
        ex_regDst = data[4:0];
        ex_regSel = sel;
        ex_regWr  = rw;
        ex_dREN   = rd;
        ex_dWEN   = wr;
        ihit      = 1'b1;
        tick();
        ihit      = 1'b0;
        ex_dREN   = 1'b0;
        ex_dWEN   = 1'b0;
        ex_halt   = 1'b0;
        ex_ALUOut = $urandom;
        ex_store  = $urandom;
    endtask

    int          ren_n, wen_n, busy_n, lat, gap, kind;
    logic [31:0] m_addr, m_data, model_load;

    initial begin
        RST = 1'b1; flush = 1'b0; ihit = 1'b0;
        ex_nPC = '0; ex_ALUOut = '0; ex_lui = '0; ex_store = '0;
        ex_regSel = ALUr; ex_regWr = 1'b0; ex_regDst = '0;
        ex_dREN = 1'b0; ex_dWEN = 1'b0; ex_halt = 1'b0;
        dif.dhit = 1'b0; dif.dload = '0;
        tick(); tick();
        chk("rst_aluout", ALUOut, 32'h0);
        chk("rst_regwr", 32'(regWr), 32'd0);
        chk("rst_regsel", 32'(regSel), 32'(ALUr));
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_ren", 32'(dif.dmemREN), 32'd0);
        chk("rst_busy", 32'(mem_busy), 32'd0);
        RST = 1'b0;
        tick();

        // ALU op: capture, no data request
        issue(32'h1234, 32'h0, 1'b0, 1'b0, ALUr, 1'b1);
        chk("alu_out", ALUOut, 32'h1234);
        chk("alu_regwr", 32'(regWr), 32'd1);
        chk("alu_busy", 32'(mem_busy), 32'd0);
        chk("alu_req", 32'(dif.dmemREN | dif.dmemWEN), 32'd0);

        // load, dhit on the third request cycle
        issue(32'h40, 32'h0, 1'b1, 1'b0, DLoad, 1'b1);
        ren_n = 0; busy_n = 0;
        for (int i = 0; i < 3; i++) begin
            dif.dhit  = (i == 2);
            dif.dload = (i == 2) ? 32'hDEADBEEF : 32'h0;
            #1;
            if (i == 0) chk("ld_addr", dif.dmemaddr, 32'h40);
            ren_n  += int'(dif.dmemREN);
            busy_n += int'(mem_busy);
            tick();
        end
        dif.dhit = 1'b0;
        chk("ld_ren_cycles", 32'(ren_n), 32'd3);
        chk("ld_busy_cycles", 32'(busy_n), 32'd2);
        for (int i = 0; i < 3; i++) begin
            dif.dload = $urandom;
            #1;
            chk("ld_hold", dmemload, 32'hDEADBEEF);
            tick();
        end

        // store serviced immediately, then held with ihit low
        issue(32'h80, 32'hCAFE, 1'b0, 1'b1, ALUr, 1'b0);
        chk("st_data", dif.dmemstore, 32'hCAFE);
        chk("st_addr", dif.dmemaddr, 32'h80);
        wen_n = 0;
        for (int i = 0; i < 5; i++) begin
            dif.dhit = (i == 0);
            #1;
            wen_n += int'(dif.dmemWEN);
            tick();
        end
        dif.dhit = 1'b0;
        chk("st_wen_once", 32'(wen_n), 32'd1);

        // flush during REQ with a coincident dhit
        issue(32'h44, 32'h3, 1'b1, 1'b0, DLoad, 1'b1);
        chk("fl_pre_ren", 32'(dif.dmemREN), 32'd1);
        flush = 1'b1; dif.dhit = 1'b1; dif.dload = 32'h11112222;
        tick();
        flush = 1'b0; dif.dhit = 1'b0;
        chk("fl_ren", 32'(dif.dmemREN), 32'd0);
        chk("fl_regwr", 32'(regWr), 32'd0);
        chk("fl_regsel", 32'(regSel), 32'(ALUr));
        chk("fl_load", dmemload, 32'hDEADBEEF);
        tick();
        chk("fl_ren_later", 32'(dif.dmemREN), 32'd0);

        // halt is sticky and blocks captures until reset
        ex_halt = 1'b1;
        issue(32'h55, 32'h0, 1'b0, 1'b0, ALUr, 1'b1);
        chk("halt_set", 32'(halt), 32'd1);
        chk("halt_capture", ALUOut, 32'h55);
        ex_ALUOut = 32'h99; ex_dREN = 1'b1; ihit = 1'b1;
        tick(); tick();
        ihit = 1'b0; ex_dREN = 1'b0;
        chk("halt_frozen", ALUOut, 32'h55);
        chk("halt_no_req", 32'(dif.dmemREN), 32'd0);
        chk("halt_sticky", 32'(halt), 32'd1);
        RST = 1'b1;
        #1;
        chk("halt_rst", 32'(halt), 32'd0);
        RST = 1'b0;
        tick();

        // asynchronous reset in the middle of a request
        issue(32'h60, 32'h7, 1'b1, 1'b0, DLoad, 1'b1);
        chk("ar_pre_ren", 32'(dif.dmemREN), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_ren", 32'(dif.dmemREN), 32'd0);
        chk("ar_busy", 32'(mem_busy), 32'd0);
        chk("ar_aluout", ALUOut, 32'h0);
        chk("ar_regwr", 32'(regWr), 32'd0);
        chk("ar_dmemload", dmemload, 32'h0);
        tick();
        RST = 1'b0;
        tick();
        model_load = 32'h0;

        // randomized transactions: one instruction at a time, random cache latency
        for (int t = 0; t < 40; t++) begin
            kind   = int'($urandom_range(0, 2));
            m_addr = $urandom;
            m_data = $urandom;
            lat    = int'($urandom_range(1, 4));
            gap    = int'($urandom_range(1, 3));
            issue(m_addr, m_data, kind == 1, kind == 2, (kind == 1) ? DLoad : ALUr, kind != 2);
            chk("rnd_aluout", ALUOut, m_addr);
            chk("rnd_npc", nPC, m_addr + 32'd4);
            chk("rnd_regdst", 32'(regDst), 32'(m_data[4:0]));
            chk("rnd_regwr", 32'(regWr), (kind != 2) ? 32'd1 : 32'd0);
            if (kind != 0) begin
                ren_n = 0; wen_n = 0; busy_n = 0;
                for (int c = 0; c < lat; c++) begin
                    dif.dhit  = (c == lat - 1);
                    dif.dload = (c == lat - 1) ? m_data : $urandom;
                    #1;
                    if (c == 0) chk("rnd_addr", dif.dmemaddr, m_addr);
                    ren_n  += int'(dif.dmemREN);
                    wen_n  += int'(dif.dmemWEN);
                    busy_n += int'(mem_busy);
                    tick();
                end
                dif.dhit = 1'b0;
                chk("rnd_ren", 32'(ren_n), (kind == 1) ? 32'(lat) : 32'd0);
                chk("rnd_wen", 32'(wen_n), (kind == 2) ? 32'(lat) : 32'd0);
                chk("rnd_busy", 32'(busy_n), 32'(lat - 1));
                if (kind == 1) model_load = m_data;
            end
            for (int g = 0; g < gap; g++) begin
                dif.dhit  = 1'($urandom_range(0, 1));
                dif.dload = $urandom;
                #1;
                chk("rnd_idle_req", 32'(dif.dmemREN | dif.dmemWEN), 32'd0);
                chk("rnd_idle_busy", 32'(mem_busy), 32'd0);
                chk("rnd_load", dmemload, model_load);
                tick();
            end
            dif.dhit = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
